// File: rtl/cacheline_burst_adaptor.sv
// Cacheline <-> burst adaptor: turns one full-line read/write from the cache
// into BEATS memory beats. Read beats are assembled into the line buffer, LSB
// beat first. A write line is serialized out of the same buffer. Completion is
// a one-cycle pmem_resp.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BURST_WIDTH-1:0] mem_wdata,
  input  logic [BURST_WIDTH-1:0] mem_rdata,
  input  logic                   mem_resp
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  // Byte-offset bits inside a line; cleared so memory always sees aligned bursts.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [BEATS-1:0][BURST_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic                              last_beat;

  assign last_beat = mem_resp && (cnt_q == CNT_W'(BEATS - 1));

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: read has priority over write; DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pmem_read) state_d = READ;
               else if (pmem_write) state_d = WRITE;
      READ:    if (last_beat) state_d = DONE;
      WRITE:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch request in IDLE, count beats and fill buffer while bursting.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    addr_d = addr_q;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          addr_d = pmem_address & ~OFF_MASK;
          cnt_d  = '0;
        end
        if (!pmem_read && pmem_write) line_d = pmem_wdata;
      end
      READ: begin
        if (mem_resp) begin
          line_d[cnt_q] = mem_rdata;
          cnt_d         = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (mem_resp) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    pmem_rdata  = line_q;
    pmem_resp   = (state_q == DONE);
    mem_read    = (state_q == READ);
    mem_write   = (state_q == WRITE);
    mem_address = addr_q;
    mem_wdata   = (state_q == WRITE) ? line_q[cnt_q] : '0;
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor. Stimulus pushes expected lines
// and write beats into queues; a negedge monitor pops and compares whenever
// the DUT completes a line or has a write beat accepted.
module tb_cacheline_burst_adaptor;
  localparam int LW = 256, BW = 64, AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pmem_address;
  logic          pmem_read, pmem_write;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp;
  logic [AW-1:0] mem_address;
  logic          mem_read, mem_write;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp;

  cacheline_burst_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int resp_cnt = 0;
  logic [LW-1:0] exp_line_q[$];
  logic [BW-1:0] exp_wbeat_q[$];
  logic [AW-1:0] exp_addr;
  logic          allow_write = 1'b0;
  logic          prev_resp = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read || mem_write) chk("mem_address", LW'(mem_address), LW'(exp_addr));
      if (mem_write && !allow_write) chk("unexpected_mem_write", 1, 0);
      if (mem_write && mem_resp) begin
        if (exp_wbeat_q.size() == 0) chk("unexpected_wbeat", 1, 0);
        else chk("mem_wdata", LW'(mem_wdata), LW'(exp_wbeat_q.pop_front()));
      end
      if (pmem_resp) begin
        resp_cnt++;
        chk("resp_single_cycle", LW'(prev_resp), 0);
        if (exp_line_q.size() == 0) chk("unexpected_pmem_resp", 1, 0);
        else chk("pmem_rdata", pmem_rdata, exp_line_q.pop_front());
      end
    end
    prev_resp = pmem_resp;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Read: request for one cycle, then strobe beats following pat (LSB first).
  task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] aligned,
                         input logic [3:0][BW-1:0] beats, input logic [7:0] pat,
                         input int pat_len, input logic also_write);
    int k = 0;
    exp_addr = aligned;
    exp_line_q.push_back(beats);
    allow_write = 1'b0;
    pmem_address = addr; pmem_read = 1'b1; pmem_write = also_write;
    pmem_wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
    tick();
    pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '1;
    for (int i = 0; i < pat_len; i++) begin
      chk("mem_read_held", LW'(mem_read), 1);
      mem_resp = pat[i];
      mem_rdata = pat[i] ? beats[k] : 64'hDEAD_DEAD_DEAD_DEAD;
      if (pat[i]) k++;
      tick();
    end
    mem_resp = 1'b0;
    chk("done_pmem_resp", LW'(pmem_resp), 1);
    chk("done_mem_read", LW'(mem_read), 0);
    tick();
    chk("idle_pmem_resp", LW'(pmem_resp), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] aligned,
                          input logic [LW-1:0] line, input logic [3:0][BW-1:0] beats);
    exp_addr = aligned;
    allow_write = 1'b1;
    for (int i = 0; i < 4; i++) exp_wbeat_q.push_back(beats[i]);
    exp_line_q.push_back(line);
    pmem_address = addr; pmem_write = 1'b1; pmem_wdata = line;
    tick();
    pmem_write = 1'b0; pmem_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk("mem_write_held", LW'(mem_write), 1);
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    chk("write_done_mem_write", LW'(mem_write), 0);
    chk("write_done_pmem_resp", LW'(pmem_resp), 1);
    tick();
    allow_write = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pmem_rdata"}, pmem_rdata, '0);
    chk({tag, "_ctrl"}, LW'({pmem_resp, mem_read, mem_write}), 0);
    chk({tag, "_mem_address"}, LW'(mem_address), 0);
    chk({tag, "_mem_wdata"}, LW'(mem_wdata), 0);
  endtask

  localparam logic [BW-1:0] B1 = 64'h1111_1111_1111_1111, B2 = 64'h2222_2222_2222_2222,
                            B3 = 64'h3333_3333_3333_3333, B4 = 64'h4444_4444_4444_4444;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][BW-1:0] rline1, rline2, rline3, wbeats;
    rline1 = {B4, B3, B2, B1};
    rline2 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
              64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    rline3 = {64'hCAFE_0004_CAFE_0004, 64'hCAFE_0003_CAFE_0003,
              64'hCAFE_0002_CAFE_0002, 64'hCAFE_0001_CAFE_0001};
    wbeats = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    rst = 1'b1; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0; exp_addr = '0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: consecutive beats
    do_read(32'h0000_1234, 32'h0000_1220, rline1, 8'b0000_1111, 4, 1'b0);
    // 2: gaps, pattern 1,0,0,1,1,0,1
    do_read(32'h0000_1234, 32'h0000_1220, rline1, 8'b0101_1001, 7, 1'b0);
    // 3: write
    do_write(32'h0000_ABCD, 32'h0000_ABC0, wbeats, wbeats);
    // 4: read and write together, read wins
    do_read(32'hDEAD_BEEF, 32'hDEAD_BEE0, rline2, 8'b0000_1111, 4, 1'b1);
    // 5: back-to-back write then read
    do_write(32'h0000_0040, 32'h0000_0040, {B1, B2, B3, B4}, {B1, B2, B3, B4});
    do_read(32'h0000_0047, 32'h0000_0040, rline3, 8'b0000_1111, 4, 1'b0);

    // 6: reset after two beats of a read
    exp_addr = 32'h0000_1220;
    pmem_address = 32'h0000_1234; pmem_read = 1'b1;
    tick();
    pmem_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = B1; tick();
    mem_rdata = B2; tick();
    mem_resp = 1'b0;
    rst = 1'b1;
    #1 chk_all_zero("midreset");
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("no_resp_after_abort", LW'(resp_cnt), 6);
    do_read(32'h0000_1234, 32'h0000_1220, rline1, 8'b0000_1111, 4, 1'b0);

    tick();
    chk("total_resp_pulses", LW'(resp_cnt), 7);
    chk("line_queue_drained", LW'(exp_line_q.size()), 0);
    chk("wbeat_queue_drained", LW'(exp_wbeat_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Sits directly downstream of the cache controller, between the cache's physical-memory port and the burst-mode main memory. Converts one full-cacheline read or write request into a burst of BEATS = LINE_WIDTH/BURST_WIDTH beats. It assembles incoming read beats into a line, or serializes a line into outgoing write beats. It then returns a single-cycle completion pulse to the cache.

Parameters:
LINE_WIDTH, 256, cacheline width in bits
BURST_WIDTH, 64, memory beat width in bits (LINE_WIDTH must be an integer multiple)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-high
pmem_address  in  ADDR_WIDTH  line address from the cache
pmem_read  in  1  cache requests a line read
pmem_write  in  1  cache requests a line write
pmem_wdata  in  LINE_WIDTH  line to write; sampled when a write is accepted
pmem_rdata  out  LINE_WIDTH  assembled read line
pmem_resp  out  1  one-cycle completion pulse to the cache
mem_address  out  ADDR_WIDTH  line-aligned burst address to memory
mem_read  out  1  burst read request
mem_write  out  1  burst write request
mem_wdata  out  BURST_WIDTH  current write beat
mem_rdata  in  BURST_WIDTH  current read beat
mem_resp  in  1  memory beat strobe; one beat transferred per high cycle

Behaviour:
- Reset: applies asynchronously while rst=1.
  - State goes to IDLE and the beat counter to 0.
  - Line buffer and latched address clear to 0.
  - All outputs are 0: pmem_rdata=0, pmem_resp=0, mem_read=0, mem_write=0, mem_wdata=0, mem_address=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - If pmem_read=1, latch pmem_address with offset bits [log2(LINE_WIDTH/8)-1:0] forced to 0, clear the counter, and go to READ.
  - Otherwise, if pmem_write=1, do the same latching and also latch pmem_wdata into the line buffer, then go to WRITE.
  - If both requests are high, read wins.
  - mem_resp is ignored in this state.
- READ:
  - mem_read=1 and mem_address=latched address for every cycle spent in READ.
  - On each cycle with mem_resp=1, store mem_rdata into buffer slice [cnt*BURST_WIDTH +: BURST_WIDTH], beat 0 at the LSBs, and increment cnt.
  - On the cycle the beat with cnt=BEATS-1 is accepted, go to DONE.
  - Gap cycles (mem_resp=0) hold the state and counter.
- WRITE:
  - mem_write=1, mem_address=latched address, and mem_wdata=buffer slice [cnt].
  - Each cycle with mem_resp=1 counts as one accepted beat and increments cnt, so mem_wdata advances the next cycle.
  - On acceptance of beat BEATS-1, go to DONE.
- DONE:
  - pmem_resp=1 for exactly this one cycle; mem_read=0 and mem_write=0.
  - For reads, pmem_rdata holds the full line from this cycle onward.
  - pmem_rdata is driven from the line buffer. It stays stable until the next transaction modifies the buffer.
  - Unconditionally go to IDLE next cycle.
  - Requests and mem_resp are ignored in DONE, so the cache must drop its request on the cycle after pmem_resp.
- Latency:
  - A request sampled in IDLE at edge T drives mem_read or mem_write from cycle T+1.
  - pmem_resp asserts the cycle after the final beat is accepted.
  - Minimum end-to-end latency is BEATS+2 cycles.
- Counter: log2(BEATS) bits. It never wraps inside a transaction because the transition to DONE occurs on the last beat.
- Request changes mid-burst: pmem_read, pmem_write, pmem_address and pmem_wdata are ignored outside IDLE; the latched copies govern the burst.
- Reset mid-burst: aborts immediately. mem_read and mem_write drop to 0 asynchronously, and no pmem_resp is produced for the aborted transaction.
- Only one outstanding transaction; there is no pipelining of requests.

Test Plan:
1. Read with consecutive beats:
   - Stimulus: pmem_read=1, pmem_address=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with mem_resp high for 4 cycles.
   - Required: mem_address=0x0000_1220; pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}; pmem_resp high for exactly 1 cycle, the cycle after beat 4.
2. Read with gaps:
   - Stimulus: same read, with mem_resp pattern 1,0,0,1,1,0,1.
   - Required: same assembled line; mem_read held high throughout; pmem_resp the cycle after the 4th strobe.
3. Write:
   - Stimulus: pmem_write=1, pmem_wdata=0xDDDD..CCCC..BBBB..AAAA (per 64-bit beat); memory asserts mem_resp for 4 cycles.
   - Required: mem_wdata sequence AAAA.., BBBB.., CCCC.., DDDD..; mem_write then drops and pmem_resp pulses once.
4. Simultaneous pmem_read=1 and pmem_write=1 in IDLE -> read burst performed; mem_write stays 0.
5. Back-to-back: a write, then a read issued the cycle after IDLE returns -> both complete correctly; the read line overwrites the buffer; exactly two pmem_resp pulses.
6. Reset mid-read:
   - Stimulus: rst asserted after 2 beats, then released; then a fresh read.
   - Required: mem_read=0 immediately and all outputs 0; no pmem_resp for the aborted read; the fresh read returns a correct 4-beat line.
